// File: rtl/macro_fifo8_incr3.sv
// macro_fifo8_incr3: 8-entry first-word-fall-through FIFO.
// The read and write pointers step through 3-bit increment ROM macros.
// Each wrap carry toggles that pointer's phase bit. All outputs decode
// from registered pointer/phase state and storage; there is no bypass.

// Small ROM macro: q = (a + 1) mod 8, c = 1 when a wraps from 7 to 0.
module macro_incr3_rom (
    input  logic [2:0] a,
    output logic [2:0] q,
    output logic       c
);

    // Table lookup for the next index and its wrap carry.
    always_comb begin
        // NOTE: every output is given a default before the case, so no path can leave it unassigned and infer a latch.
        q = 3'd0;
        c = 1'b0;
        case (a)
            3'd0: begin q = 3'd1; c = 1'b0; end
            3'd1: begin q = 3'd2; c = 1'b0; end
            3'd2: begin q = 3'd3; c = 1'b0; end
            3'd3: begin q = 3'd4; c = 1'b0; end
            3'd4: begin q = 3'd5; c = 1'b0; end
            3'd5: begin q = 3'd6; c = 1'b0; end
            3'd6: begin q = 3'd7; c = 1'b0; end
            3'd7: begin q = 3'd0; c = 1'b1; end
            default: begin q = 3'd0; c = 1'b0; end
        endcase
    end

endmodule

module macro_fifo8_incr3 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [3:0]            o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [2:0]            wr_ptr_q, wr_ptr_d;
    logic                  wr_phase_q, wr_phase_d;
    logic [2:0]            rd_ptr_q, rd_ptr_d;
    logic                  rd_phase_q, rd_phase_d;
    logic [DATA_WIDTH-1:0] mem [0:7];

    logic [2:0] wr_ptr_inc, rd_ptr_inc;
    logic       wr_carry, rd_carry;
    logic       push, pop;
    logic       ptr_eq;

    macro_incr3_rom u_wr_incr (
        .a (wr_ptr_q),
        .q (wr_ptr_inc),
        .c (wr_carry)
    );

    macro_incr3_rom u_rd_incr (
        .a (rd_ptr_q),
        .q (rd_ptr_inc),
        .c (rd_carry)
    );

    // Status decode: equal pointers mean empty when phases agree, full when they differ.
    always_comb begin
        ptr_eq  = (wr_ptr_q == rd_ptr_q);
        o_empty = ptr_eq && (wr_phase_q == rd_phase_q);
        o_full  = ptr_eq && (wr_phase_q != rd_phase_q);
        o_ready = !o_full;
        o_valid = !o_empty;
        o_count = {wr_phase_q ^ rd_phase_q, 3'b000} + {1'b0, wr_ptr_q} - {1'b0, rd_ptr_q};
        o_data  = mem[rd_ptr_q];
        push    = i_valid && o_ready;
        pop     = o_valid && i_ready;
    end

    // Next pointer/phase state; flush overrides both push and pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_phase_d = wr_phase_q;
        rd_ptr_d   = rd_ptr_q;
        rd_phase_d = rd_phase_q;
        if (i_flush) begin
            wr_ptr_d   = 3'd0;
            wr_phase_d = 1'b0;
            rd_ptr_d   = 3'd0;
            rd_phase_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_inc;
                wr_phase_d = wr_phase_q ^ wr_carry;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_inc;
                rd_phase_d = rd_phase_q ^ rd_carry;
            end
        end
    end

    // Pointer and phase registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            wr_ptr_q   <= 3'd0;
            wr_phase_q <= 1'b0;
            rd_ptr_q   <= 3'd0;
            rd_phase_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_phase_q <= wr_phase_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_phase_q <= rd_phase_d;
        end
    end

    // Storage write on an accepted push; a flush suppresses the write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; pointers alone define which entries are valid.
        if (push && !i_flush) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_macro_fifo8_incr3.sv
// Directed self-checking bench for macro_fifo8_incr3.
module tb_macro_fifo8_incr3;

    logic        clk;
    logic        resetn;
    logic        i_flush;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;
    logic [3:0]  o_count;
    logic        o_full;
    logic        o_empty;

    int checks = 0;
    int errors = 0;

    macro_fifo8_incr3 #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_data  = 32'h0;
        i_ready = 1'b0;
        #12;
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_full",  {31'd0, o_full},  32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_count", {28'd0, o_count}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // Fill with 0x10..0x17 while the consumer stalls.
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data  = 32'h10 + i;
            step();
            check("fill_count", {28'd0, o_count}, i + 1);
        end
        check("fill_full",  {31'd0, o_full},  32'd1);
        check("fill_ready", {31'd0, o_ready}, 32'd0);
        i_data = 32'hFF;
        step();
        check("drop_count", {28'd0, o_count}, 32'd8);
        check("drop_head",  o_data, 32'h10);

        // Drain in order.
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_data", o_data, 32'h10 + i);
            step();
        end
        check("drain_empty", {31'd0, o_empty}, 32'd1);
        check("drain_valid", {31'd0, o_valid}, 32'd0);
        check("drain_count", {28'd0, o_count}, 32'd0);

        // Preload 3, then stream 20 words across two pointer wraps.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 32'h100 + i;
            step();
        end
        check("pre_count", {28'd0, o_count}, 32'd3);
        i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_data = 32'h103 + k;
            check("stream_data", o_data, 32'h100 + k);
            step();
            check("stream_count", {28'd0, o_count}, 32'd3);
        end
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("tail_data", o_data, 32'h114 + k);
            step();
        end
        check("tail_empty", {31'd0, o_empty}, 32'd1);

        // Full with push+pop: only the pop fires.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = 32'h20 + i;
            step();
        end
        check("full2_full", {31'd0, o_full}, 32'd1);
        i_data  = 32'hFF;
        i_ready = 1'b1;
        step();
        check("fpp_count", {28'd0, o_count}, 32'd7);
        check("fpp_ready", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("fpp_data", o_data, 32'h20 + i);
            step();
        end
        check("fpp_empty", {31'd0, o_empty}, 32'd1);

        // Empty with push+pop: only the push fires.
        i_valid = 1'b1;
        i_data  = 32'h55;
        step();
        check("epp_count", {28'd0, o_count}, 32'd1);
        check("epp_data",  o_data, 32'h55);
        i_valid = 1'b0;
        step();
        check("epp_empty", {31'd0, o_empty}, 32'd1);

        // Flush beats simultaneous push and pop.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = 32'h30 + i;
            step();
        end
        check("pfl_count", {28'd0, o_count}, 32'd5);
        i_flush = 1'b1;
        i_data  = 32'h99;
        i_ready = 1'b1;
        step();
        i_flush = 1'b0;
        check("fl_count", {28'd0, o_count}, 32'd0);
        check("fl_empty", {31'd0, o_empty}, 32'd1);
        check("fl_valid", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b0;
        i_data  = 32'h77;
        step();
        check("fl_push_data",  o_data, 32'h77);
        check("fl_push_count", {28'd0, o_count}, 32'd1);

        // Hold 6 entries, then assert reset between edges.
        for (int i = 0; i < 5; i++) begin
            i_data = 32'h40 + i;
            step();
        end
        i_valid = 1'b0;
        check("pre_rst_count", {28'd0, o_count}, 32'd6);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_count", {28'd0, o_count}, 32'd0);
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        resetn  = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h88;
        step();
        i_valid = 1'b0;
        check("post_rst_data",  o_data, 32'h88);
        check("post_rst_count", {28'd0, o_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/macro_fifo8_incr3.md
Name: macro_fifo8_incr3

Overview:
8-entry first-word-fall-through FIFO. The 3-bit read and write pointers advance through instances of the 3-bit increment ROM macro (q = next index, c = wrap carry). Each carry toggles that pointer's phase bit. Sits between the fetch/issue stages of the Taurus 3001 pipeline as the standard small decoupling buffer. All outputs are derived from registered pointer/phase state and storage.

Parameters:
DATA_WIDTH, 32, width of each stored entry.

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
i_flush  input  1  synchronous flush; empties FIFO next edge
i_valid  input  1  write side: data valid
i_data  input  DATA_WIDTH  write side: data
o_ready  output  1  write side: FIFO can accept (not full)
o_valid  output  1  read side: head entry valid (not empty)
o_data  output  DATA_WIDTH  read side: head entry, mem[rd_ptr]
i_ready  input  1  read side: consumer accepts head
o_count  output  4  occupancy, 0..8
o_full  output  1  occupancy == 8
o_empty  output  1  occupancy == 0

Behaviour:
- State: wr_ptr[2:0], wr_phase, rd_ptr[2:0], rd_phase, mem[0:7] of DATA_WIDTH.
- Reset (resetn low, asynchronous): wr_ptr=rd_ptr=0, wr_phase=rd_phase=0. Hence o_empty=1, o_full=0, o_valid=0, o_ready=1, o_count=0. mem is not reset; o_data is don't-care while o_valid=0.
- Reset released mid-traffic: all in-flight content is lost. First push after release lands at index 0.
- Status decode (combinational from registers):
  - empty = (wr_ptr==rd_ptr) && (wr_phase==rd_phase)
  - full = (wr_ptr==rd_ptr) && (wr_phase!=rd_phase)
  - o_ready = !full; o_valid = !empty
- o_count = {wr_phase^rd_phase, 3'b000} + wr_ptr - rd_ptr, computed 4-bit modulo 16. Range is 0..8.
- Push fires when i_valid && o_ready. On the edge: mem[wr_ptr] <= i_data; wr_ptr <= incr3(wr_ptr).q; wr_phase toggles iff incr3(wr_ptr).c.
- Pop fires when o_valid && i_ready. On the edge: rd_ptr <= incr3(rd_ptr).q; rd_phase toggles iff incr3(rd_ptr).c.
- Latency:
  - A pushed entry is visible on o_valid/o_data the cycle after the push edge.
  - There is no same-cycle bypass, so an empty FIFO never presents i_data combinationally.
- Simultaneous push and pop, neither full nor empty: both fire; count unchanged; pointers each advance by 1.
- Full, push and pop both requested: only the pop fires (o_ready=0). The next cycle shows count 7 and o_ready=1.
- Empty, push and pop both requested: only the push fires (o_valid=0). The next cycle shows count 1.
- Wrap-around: a pointer at 7 advances to 0 with c=1 and flips its phase. The full/empty decode must be correct across any number of wraps.
- i_flush:
  - On the next edge, set wr_ptr=rd_ptr=0 and both phases=0.
  - Flush has priority over push and pop in the same cycle; neither takes effect.
  - Flush does not clear mem.
- Handshake rules:
  - o_valid and o_data stay stable until popped or flushed.
  - o_ready does not depend combinationally on i_valid.
  - o_valid does not depend combinationally on i_ready.

Test Plan:
- Reset, then 8 pushes of 0x10..0x17 with i_ready=0 -> o_count steps 1..8; after the 8th edge o_full=1, o_ready=0. A 9th push with 0xFF is dropped.
- From full, hold i_ready=1 for 8 cycles -> o_data reads 0x10..0x17 in order; then o_empty=1, o_valid=0, o_count=0.
- Continuous streaming of 20 words with i_valid=i_ready=1 after 3 preload pushes -> o_count holds 3; data order is preserved across 2 pointer wraps and the phase flips.
- Full with push+pop requested in the same cycle -> count 7 and o_ready=1 next cycle; 0xFF is not written. Empty with push+pop -> count 1, and o_data equals the pushed value next cycle.
- Load 5 entries, assert i_flush together with i_valid=1 and i_ready=1 -> next cycle o_count=0, o_empty=1, and the next push lands at index 0.
- Assert resetn=0 asynchronously mid-cycle with 6 entries held -> o_valid=0, o_count=0, and o_ready=1 without waiting for a clock edge.
